// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC SPI output stage.
// No logic here: frame widths, the DAC config nibble layout and the FSM state encoding.
// Also holds the helper that builds a 16-bit DAC write frame from config bits and a sample.
package dac_pkg;

  localparam int SAMPLE_W       = 12;
  localparam int DAC_FRAME_BITS = 16;
  // Two SCLK toggles per frame bit.
  localparam int HALF_PERIODS   = 2 * DAC_FRAME_BITS;

  // Upper nibble of an MCP4921 write word. "buf" is a reserved word, hence buf_en.
  typedef struct packed {
    logic ab;
    logic buf_en;
    logic ga_n;
    logic shdn_n;
  } dac_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CS_HOLD,
    LATCH
  } dac_state_t;

  // Samples go out unmodified below the config nibble.
  function automatic logic [DAC_FRAME_BITS-1:0] make_frame(input dac_cfg_t cfg,
                                                           input logic [SAMPLE_W-1:0] sample);
    return {cfg, sample};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Purpose: small synchronous FIFO buffering samples ahead of the SPI serialiser.
// Latency: a pushed word is visible on pop_dat (show-ahead) the cycle after the push.
// Backpressure: none upstream; a push while full is ignored unless a pop happens in the same cycle.
// Ports: clk/reset (sync, active high), push/push_dat in, pop in, pop_dat/full/empty/count out.
module sample_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  // Storage needs no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Purpose: buffers 12-bit samples and sends each as a 16-bit SPI write to an MCP4921-class DAC, then pulses LDAC.
// Latency: push into an empty FIFO reaches LOAD 1 cycle later; frame period is 1 + 34*CLK_DIV cycles plus 1 IDLE.
// Backpressure: none; a strobe arriving while the FIFO is full (and not popping) is dropped and sets sticky overflow.
// Ports: clk, reset (sync, active high), valid_in/sample_in strobe, clear_ovf; SPI pins dac_cs_n/dac_sclk/dac_mosi,
//        dac_ldac_n latch strobe; status busy, overflow, fifo_count.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] CFG_BITS   = 4'b0011
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          clear_ovf,
  output logic                          dac_cs_n,
  output logic                          dac_sclk,
  output logic                          dac_mosi,
  output logic                          dac_ldac_n,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV_W = $clog2(CLK_DIV);

  dac_state_t                state;
  logic [DIV_W-1:0]          div_cnt;
  logic [4:0]                half_cnt;
  logic [DAC_FRAME_BITS-1:0] shreg;
  logic                      div_term;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [SAMPLE_W-1:0]       fifo_dat;
  logic [DAC_FRAME_BITS-1:0] next_frame;

  assign fifo_pop   = (state == LOAD) && !fifo_empty;
  assign fifo_push  = valid_in && (!fifo_full || fifo_pop);
  assign next_frame = make_frame(dac_cfg_t'(CFG_BITS), fifo_dat);
  assign div_term   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign busy       = (state != IDLE);

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (sample_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Sticky drop flag; a new drop in the same cycle as clear_ovf keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (valid_in && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= 1'b1;
      shreg      <= '0;
      div_cnt    <= '0;
      half_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          shreg    <= next_frame;
          dac_mosi <= next_frame[DAC_FRAME_BITS-1];
          dac_cs_n <= 1'b0;
          div_cnt  <= '0;
          half_cnt <= '0;
          state    <= SHIFT;
        end

        SHIFT: begin
          if (div_term) begin
            div_cnt  <= '0;
            dac_sclk <= ~dac_sclk;
            half_cnt <= half_cnt + 1'b1;
            if (dac_sclk) begin
              // Falling toggle. The last one closes the frame and leaves MOSI on bit 0.
              if (half_cnt == 5'(HALF_PERIODS - 1)) begin
                dac_cs_n <= 1'b1;
                state    <= CS_HOLD;
              end else begin
                // Rotate rather than shift so every register bit stays live.
                shreg    <= {shreg[DAC_FRAME_BITS-2:0], shreg[DAC_FRAME_BITS-1]};
                dac_mosi <= shreg[DAC_FRAME_BITS-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        CS_HOLD: begin
          if (div_term) begin
            div_cnt    <= '0;
            dac_ldac_n <= 1'b0;
            state      <= LATCH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        LATCH: begin
          if (div_term) begin
            div_cnt    <= '0;
            dac_ldac_n <= 1'b1;
            state      <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: u0 runs default parameters, u1 runs CLK_DIV=2.
// Directed strobes push expected SPI words into per-instance queues; a negedge monitor
// decodes the SPI pins and checks frame content, CS/LDAC/busy timing against them.
module tb_dac_spi_tx;
  import dac_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, vld0, clr0, rst1, vld1, clr1;
  logic [11:0] smp0, smp1;
  logic        cs_n0, sclk0, mosi0, ldac_n0, busy0, ovf0;
  logic        cs_n1, sclk1, mosi1, ldac_n1, busy1, ovf1;
  logic [2:0]  cnt0, cnt1;

  dac_spi_tx u0 (
    .clk(clk), .reset(rst0), .valid_in(vld0), .sample_in(smp0), .clear_ovf(clr0),
    .dac_cs_n(cs_n0), .dac_sclk(sclk0), .dac_mosi(mosi0), .dac_ldac_n(ldac_n0),
    .busy(busy0), .overflow(ovf0), .fifo_count(cnt0)
  );

  dac_spi_tx #(.CLK_DIV(2)) u1 (
    .clk(clk), .reset(rst1), .valid_in(vld1), .sample_in(smp1), .clear_ovf(clr1),
    .dac_cs_n(cs_n1), .dac_sclk(sclk1), .dac_mosi(mosi1), .dac_ldac_n(ldac_n1),
    .busy(busy1), .overflow(ovf1), .fifo_count(cnt1)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Scoreboard queues of expected 16-bit SPI words.
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  // Monitor state, one slot per instance.
  int          nbits[2], cs_cnt[2], gap[2], ldac_cnt[2], busy_cnt[2];
  bit          in_frame[2], await_ldac[2], busy_bad[2], mosi_err[2];
  logic        prev_cs[2], prev_sclk[2], prev_mosi[2], prev_ldac[2], prev_busy[2];
  logic [15:0] sh[2];

  task automatic mon(input int i, input logic rst, input logic cs_n, input logic sclk,
                     input logic mosi, input logic ldac_n, input logic bsy, input int div);
    logic [15:0] want;
    if (rst) begin
      in_frame[i]   = 1'b0;
      await_ldac[i] = 1'b0;
      busy_bad[i]   = 1'b1;
    end else begin
      // LDAC: must follow a completed frame by div cycles and last div cycles.
      if (await_ldac[i]) gap[i]++;
      if (prev_ldac[i] && !ldac_n) begin
        check($sformatf("u%0d_ldac_after_frame", i), 32'(await_ldac[i]), 32'd1);
        if (await_ldac[i]) check($sformatf("u%0d_ldac_delay", i), 32'(gap[i]), 32'(div));
        await_ldac[i] = 1'b0;
        ldac_cnt[i]   = 0;
      end
      if (!ldac_n) ldac_cnt[i]++;
      if (!prev_ldac[i] && ldac_n) check($sformatf("u%0d_ldac_width", i), 32'(ldac_cnt[i]), 32'(div));

      // SPI frame capture on rising SCLK while CS is low.
      if (prev_cs[i] && !cs_n) begin
        in_frame[i] = 1'b1;
        nbits[i]    = 0;
        cs_cnt[i]   = 0;
        mosi_err[i] = 1'b0;
      end
      if (!cs_n) begin
        cs_cnt[i]++;
        if (sclk && !prev_sclk[i]) begin
          sh[i] = {sh[i][14:0], mosi};
          nbits[i]++;
        end else if (sclk && prev_sclk[i] && (mosi != prev_mosi[i])) begin
          mosi_err[i] = 1'b1;
        end
      end
      if (!prev_cs[i] && cs_n && in_frame[i]) begin
        in_frame[i] = 1'b0;
        check($sformatf("u%0d_bit_count", i), 32'(nbits[i]), 32'd16);
        check($sformatf("u%0d_cs_low_cycles", i), 32'(cs_cnt[i]), 32'(32 * div));
        check($sformatf("u%0d_mosi_stable", i), 32'(mosi_err[i]), 32'd0);
        if (i == 0 ? exp0.size() == 0 : exp1.size() == 0) begin
          check($sformatf("u%0d_unexpected_frame", i), 32'(sh[i]), 32'hFFFF_FFFF);
        end else begin
          want = (i == 0) ? exp0.pop_front() : exp1.pop_front();
          check($sformatf("u%0d_frame", i), 32'(sh[i]), 32'(want));
        end
        await_ldac[i] = 1'b1;
        gap[i]        = 0;
      end

      // busy: one continuous stretch of 1 + 34*div cycles per frame.
      if (!prev_busy[i] && bsy) begin
        busy_cnt[i] = 0;
        busy_bad[i] = 1'b0;
      end
      if (bsy) busy_cnt[i]++;
      if (prev_busy[i] && !bsy && !busy_bad[i])
        check($sformatf("u%0d_busy_cycles", i), 32'(busy_cnt[i]), 32'(1 + 34 * div));
    end
    prev_cs[i]   = cs_n;
    prev_sclk[i] = sclk;
    prev_mosi[i] = mosi;
    prev_ldac[i] = ldac_n;
    prev_busy[i] = bsy;
  endtask

  always @(negedge clk) begin
    mon(0, rst0, cs_n0, sclk0, mosi0, ldac_n0, busy0, 4);
    mon(1, rst1, cs_n1, sclk1, mosi1, ldac_n1, busy1, 2);
  end

  // Called positioned 1 time unit after a posedge; leaves the bench there again.
  task automatic drive(input int i, input logic [11:0] s, input bit sent);
    if (i == 0) begin
      vld0 = 1'b1; smp0 = s;
      if (sent) exp0.push_back({4'b0011, s});
    end else begin
      vld1 = 1'b1; smp1 = s;
      if (sent) exp1.push_back({4'b0011, s});
    end
    @(posedge clk); #1;
    vld0 = 1'b0;
    vld1 = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    repeat (3) begin @(posedge clk); #1; end
    while (((i == 0) ? (busy0 || cnt0 != 0) : (busy1 || cnt1 != 0)) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("u%0d_idle_within_budget", i), 32'(n < budget), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

  initial begin
    int r, n, lc;
    logic ps;
    rst0 = 1'b1; rst1 = 1'b1;
    vld0 = 1'b0; vld1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    smp0 = '0; smp1 = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 32'(cs_n0), 32'd1);
    check("rst_sclk", 32'(sclk0), 32'd0);
    check("rst_mosi", 32'(mosi0), 32'd0);
    check("rst_ldac_n", 32'(ldac_n0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_overflow", 32'(ovf0), 32'd0);
    check("rst_fifo_count", 32'(cnt0), 32'd0);
    check("rst_u1_cs_n", 32'(cs_n1), 32'd1);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    // 1: single sample A5C -> 3A5C.
    vld0 = 1'b1; smp0 = 12'hA5C; exp0.push_back(16'h3A5C);
    @(posedge clk); #1; vld0 = 1'b0;
    wait_idle(0, 400);

    // 2: four back-to-back strobes, all fit in the FIFO.
    drive(0, 12'd11, 1'b1);
    drive(0, 12'd22, 1'b1);
    drive(0, 12'd33, 1'b1);
    drive(0, 12'd44, 1'b1);
    @(negedge clk);
    check("t2_overflow", 32'(ovf0), 32'd0);
    @(posedge clk); #1;
    wait_idle(0, 1000);
    check("t2_overflow_end", 32'(ovf0), 32'd0);

    // 3: six strobes; sample 5 finds the FIFO full and is dropped.
    for (int k = 0; k < 5; k++) drive(0, 12'(k), 1'b1);
    vld0 = 1'b1; smp0 = 12'd5;
    @(negedge clk);
    check("t3_ovf_before_drop", 32'(ovf0), 32'd0);
    @(posedge clk); #1;
    vld0 = 1'b1; smp0 = 12'd6; clr0 = 1'b1;   // another drop coincident with clear
    @(negedge clk);
    check("t3_ovf_after_drop", 32'(ovf0), 32'd1);
    @(posedge clk); #1;
    vld0 = 1'b0; clr0 = 1'b0;
    @(negedge clk);
    check("t3_set_beats_clear", 32'(ovf0), 32'd1);
    check("t3_fifo_full", 32'(cnt0), 32'd4);
    @(posedge clk); #1;
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    @(negedge clk);
    check("t3_ovf_cleared", 32'(ovf0), 32'd0);
    @(posedge clk); #1;
    wait_idle(0, 2000);

    // 5: FIFO full, push lands in the LOAD cycle of the next frame.
    drive(0, 12'h100, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    for (int k = 1; k < 5; k++) drive(0, 12'h100 + 12'(k), 1'b1);
    @(negedge clk);
    check("t5_fifo_full", 32'(cnt0), 32'd4);
    n = 0;
    while (busy0 && n < 400) begin @(negedge clk); n++; end
    check("t5_frame_end_within_budget", 32'(n < 400), 32'd1);
    @(posedge clk); #1;
    vld0 = 1'b1; smp0 = 12'h105; exp0.push_back(16'h3105);
    @(negedge clk);
    check("t5_in_load", 32'(busy0), 32'd1);
    @(posedge clk); #1;
    vld0 = 1'b0;
    @(negedge clk);
    check("t5_fifo_count_kept", 32'(cnt0), 32'd4);
    check("t5_no_overflow", 32'(ovf0), 32'd0);
    @(posedge clk); #1;
    wait_idle(0, 2000);

    // 4: reset at bit 7 with one more sample queued; both are lost.
    drive(0, 12'h7E7, 1'b0);
    drive(0, 12'h123, 1'b0);
    r = 0; n = 0; ps = sclk0;
    while (r < 7 && n < 500) begin
      @(negedge clk);
      if (sclk0 && !ps) r++;
      ps = sclk0;
      n++;
    end
    check("t4_reach_bit7", 32'(r), 32'd7);
    @(posedge clk); #1;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk);
    check("t4_cs_n", 32'(cs_n0), 32'd1);
    check("t4_sclk", 32'(sclk0), 32'd0);
    check("t4_ldac_n", 32'(ldac_n0), 32'd1);
    check("t4_fifo_count", 32'(cnt0), 32'd0);
    check("t4_busy", 32'(busy0), 32'd0);
    lc = 0;
    repeat (150) begin
      @(negedge clk);
      if (!ldac_n0) lc++;
    end
    check("t4_no_ldac_pulse", 32'(lc), 32'd0);
    @(posedge clk); #1;
    drive(0, 12'h456, 1'b1);
    wait_idle(0, 400);

    // 6: boundary samples on both clock dividers.
    drive(0, 12'hFFF, 1'b1);
    drive(0, 12'h000, 1'b1);
    wait_idle(0, 600);
    drive(1, 12'hFFF, 1'b1);
    drive(1, 12'h000, 1'b1);
    wait_idle(1, 400);

    check("u0_all_frames_seen", 32'(exp0.size()), 32'd0);
    check("u1_all_frames_seen", 32'(exp1.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
